nr4sd_seq_multiplier: RTL and testbench

Parametrised, iterative signed radix-4 multiplier. It recodes operand A one digit per clock and accumulates digit×B into a 2N-bit product. A mode input selects the recoding: classic Modified Booth (MB) for every digit, or NR4SD- for the lower N/2-1 digits with an MB top digit. It succeeds the fixed 16-bit combinational NR4SD- encoder by adding a width parameter, a sequential datapath, a start/done handshake and a per-cycle digit observation port.

---
 rtl/nr4sd_seq_multiplier.sv | 131 +++++++++++++
 tb/tb_nr4sd_seq_multiplier.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nr4sd_seq_multiplier.sv
// Iterative signed radix-4 multiplier: recodes a one digit per cycle (Modified Booth
// or NR4SD- with an MB top digit) and accumulates digit*b into a 2N-bit product.
module nr4sd_seq_multiplier #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p,
    output logic [2:0]     digit
);
    localparam int D  = N / 2;
    localparam int JW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     a_sh;
    logic [2*N-1:0]   b_sh;
    logic [2*N-1:0]   acc;
    logic [2*N-1:0]   pp;
    logic             mode_r;
    logic             carry;
    logic             prev;
    logic [JW-1:0]    j;

    logic             last;
    logic             a0, a1;
    logic             np, nm, c1, carry_nxt, mb_in;
    logic [2:0]       d;

    assign last = (j == JW'(D - 1));
    assign a0   = a_sh[0];
    assign a1   = a_sh[1];

    // NR4SD- digit pair from two half-adder stages; MB formula is reused for the top digit
    always_comb begin
        np        = a0 ^ carry;
        c1        = a0 & carry;
        nm        = a1 ^ c1;
        carry_nxt = a1 | c1;
        mb_in     = mode_r ? carry : prev;
        d         = 3'b000;
        if (mode_r && !last) begin
            case ({nm, np})
                2'b00:   d = 3'b000;
                2'b01:   d = 3'b001;
                2'b10:   d = 3'b110;
                default: d = 3'b111;
            endcase
        end else begin
            case ({a1, a0, mb_in})
                3'b000:  d = 3'b000;
                3'b001:  d = 3'b001;
                3'b010:  d = 3'b001;
                3'b011:  d = 3'b010;
                3'b100:  d = 3'b110;
                3'b101:  d = 3'b111;
                3'b110:  d = 3'b111;
                default: d = 3'b000;
            endcase
        end
    end

    // b_sh already carries the 4^j weight, so wrap-around in 2N bits is exact
    always_comb begin
        pp = '0;
        case (d)
            3'b001:  pp = b_sh;
            3'b010:  pp = b_sh << 1;
            3'b111:  pp = -b_sh;
            3'b110:  pp = -(b_sh << 1);
            default: pp = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            p      <= '0;
            mode_r <= 1'b0;
            carry  <= 1'b0;
            prev   <= 1'b0;
            j      <= '0;
        end else begin
            state <= state_nxt;
            if (state != RUN) begin
                if (start) begin
                    a_sh   <= a;
                    b_sh   <= {{N{b[N-1]}}, b};
                    mode_r <= mode;
                    carry  <= 1'b0;
                    prev   <= 1'b0;
                    acc    <= '0;
                    j      <= '0;
                end
            end else begin
                acc   <= acc + pp;
                a_sh  <= {2'b00, a_sh[N-1:2]};
                b_sh  <= b_sh << 2;
                prev  <= a1;
                carry <= carry_nxt;
                j     <= j + JW'(1);
                if (last) p <= acc + pp;
            end
        end
    end

    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign digit = (state == RUN) ? d : 3'b000;

endmodule

// File: tb/tb_nr4sd_seq_multiplier.sv
// Bench for nr4sd_seq_multiplier: directed scenarios on N=16 plus randomized
// product checks on N=8 and N=32 instances against plain signed arithmetic.
module tb_nr4sd_seq_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run = 0;
    int fails = 0;

    logic        s16 = 0, m16 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic        busy16, done16;
    logic [31:0] p16;
    logic [2:0]  dg16;

    logic        s8 = 0, m8 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic        busy8, done8;
    logic [15:0] p8;
    logic [2:0]  dg8;

    logic        s32 = 0, m32 = 0;
    logic [31:0] a32 = 0, b32 = 0;
    logic        busy32, done32;
    logic [63:0] p32;
    logic [2:0]  dg32;

    nr4sd_seq_multiplier #(.N(16)) dut16 (.clk(clk), .rst(rst), .start(s16), .mode(m16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16), .digit(dg16));
    nr4sd_seq_multiplier #(.N(8)) dut8 (.clk(clk), .rst(rst), .start(s8), .mode(m8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8), .digit(dg8));
    nr4sd_seq_multiplier #(.N(32)) dut32 (.clk(clk), .rst(rst), .start(s32), .mode(m32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .p(p32), .digit(dg32));

    // Runs one N=16 multiplication; records digits, busy cycles and the done cycle (-1 on timeout).
    task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic mv,
                         output logic [31:0] pv, output int dig[8],
                         output int busy_cnt, output int done_cyc);
        int nb;
        nb = 0; busy_cnt = 0; done_cyc = -1; pv = '0;
        for (int k = 0; k < 8; k++) dig[k] = 99;
        @(negedge clk);
        a16 = av; b16 = bv; m16 = mv; s16 = 1'b1;
        @(negedge clk);
        s16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); m16 = 1'($urandom);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (busy16) begin
                if (nb < 8) dig[nb] = int'($signed(dg16));
                nb++;
                busy_cnt++;
            end
            if (done16) begin
                done_cyc = cyc;
                pv = p16;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests_run++;
        if ({busy16, done16, p16, dg16} !== '0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b p=%h digit=%b, required all zero",
                     busy16, done16, p16, dg16);
        end
        tests_run++;
        if ({busy8, done8, p8, busy32, done32, p32} !== '0) begin
            fails++;
            $display("FAIL reset_state_n8_n32: p8=%h p32=%h, required zero", p8, p32);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] pv;
        int dig[8];
        int bc, dc;
        for (int m = 0; m < 2; m++) begin
            run16(16'h7FFF, 16'h7FFF, 1'(m), pv, dig, bc, dc);
            tests_run++;
            if (pv !== 32'h3FFF0001) begin
                fails++;
                $display("FAIL max_pos mode=%0d: p=%h, required 3fff0001", m, pv);
            end
            tests_run++;
            if (bc != 8 || dc != 9) begin
                fails++;
                $display("FAIL latency16 mode=%0d: busy=%0d done_cyc=%0d, required 8 and 9", m, bc, dc);
            end
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (p16 !== 32'h3FFF0001 || done16 !== 1'b0) begin
            fails++;
            $display("FAIL p_hold: p=%h done=%b, required 3fff0001 and 0", p16, done16);
        end
    endtask

    task automatic test_extremes();
        logic [31:0] pv;
        int dig[8];
        int bc, dc;
        for (int m = 0; m < 2; m++) begin
            run16(16'h8000, 16'h8000, 1'(m), pv, dig, bc, dc);
            tests_run++;
            if (pv !== 32'h40000000) begin
                fails++;
                $display("FAIL min_min mode=%0d: p=%h, required 40000000", m, pv);
            end
            run16(16'h8000, 16'h0001, 1'(m), pv, dig, bc, dc);
            tests_run++;
            if (pv !== 32'hFFFF8000) begin
                fails++;
                $display("FAIL min_one mode=%0d: p=%h, required ffff8000", m, pv);
            end
        end
    endtask

    task automatic test_digits();
        logic [31:0] pv;
        int dig[8];
        int bc, dc;
        int exp_mb[8] = '{-2, 2, 0, 0, 0, 0, 0, 0};
        int exp_nr[8] = '{-2, -2, 1, 0, 0, 0, 0, 0};
        for (int m = 0; m < 2; m++) begin
            run16(16'd6, 16'd1, 1'(m), pv, dig, bc, dc);
            for (int k = 0; k < 8; k++) begin
                tests_run++;
                if (dig[k] != (m == 0 ? exp_mb[k] : exp_nr[k])) begin
                    fails++;
                    $display("FAIL digit mode=%0d j=%0d: got %0d, required %0d", m, k, dig[k],
                             (m == 0 ? exp_mb[k] : exp_nr[k]));
                end
            end
            tests_run++;
            if (pv !== 32'd6) begin
                fails++;
                $display("FAIL six_times_one mode=%0d: p=%h, required 6", m, pv);
            end
        end
        @(negedge clk);
        tests_run++;
        if (dg16 !== 3'b000 || busy16 !== 1'b0) begin
            fails++;
            $display("FAIL digit_idle: digit=%b busy=%b, required 000 and 0", dg16, busy16);
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        int want;
        ndone = 0;
        @(negedge clk);
        a16 = 16'd3; b16 = 16'hFFFB; m16 = 1'b0; s16 = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (done16) begin
                ndone++;
                want = 9 * ndone;
                tests_run++;
                if (cyc != want || p16 !== 32'hFFFFFFF1 || busy16 !== 1'b0) begin
                    fails++;
                    $display("FAIL back_to_back #%0d: cycle=%0d p=%h busy=%b, required cycle %0d p fffffff1 busy 0",
                             ndone, cyc, p16, busy16, want);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (ndone != 3) begin
            fails++;
            $display("FAIL back_to_back_count: got %0d done pulses, required 3", ndone);
        end
        s16 = 1'b0;
        repeat (12) @(negedge clk);
        tests_run++;
        if (busy16 !== 1'b0 || done16 !== 1'b0) begin
            fails++;
            $display("FAIL back_to_back_idle: busy=%b done=%b, required 0 0", busy16, done16);
        end
    endtask

    task automatic test_start_in_run();
        int dc;
        dc = -1;
        @(negedge clk);
        a16 = 16'hFFF9; b16 = 16'd9; m16 = 1'b1; s16 = 1'b1;
        @(negedge clk);
        s16 = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 3) begin
                s16 = 1'b1; a16 = 16'h7FFF; b16 = 16'h1234; m16 = 1'b0;
            end
            if (cyc == 4) s16 = 1'b0;
            if (cyc == 5) begin
                tests_run++;
                if (p16 !== 32'hFFFFFFF1) begin
                    fails++;
                    $display("FAIL p_during_run: p=%h, required previous fffffff1", p16);
                end
            end
            if (done16) begin
                dc = cyc;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (dc != 9 || p16 !== 32'hFFFFFFC1) begin
            fails++;
            $display("FAIL start_in_run: done_cyc=%0d p=%h, required 9 and ffffffc1", dc, p16);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] pv;
        int dig[8];
        int bc, dc;
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h0057; m16 = 1'b0; s16 = 1'b1;
        @(negedge clk);
        s16 = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy16 !== 1'b1) begin
            fails++;
            $display("FAIL run_before_reset: busy=%b, required 1", busy16);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({busy16, done16, p16, dg16} !== '0) begin
            fails++;
            $display("FAIL async_reset: busy=%b done=%b p=%h digit=%b, required all zero",
                     busy16, done16, p16, dg16);
        end
        @(negedge clk);
        rst = 1'b0;
        run16(16'hFFFF, 16'hFFFF, 1'b1, pv, dig, bc, dc);
        tests_run++;
        if (pv !== 32'd1 || dc != 9) begin
            fails++;
            $display("FAIL after_reset: p=%h done_cyc=%0d, required 1 and 9", pv, dc);
        end
    endtask

    task automatic test_random16();
        logic [31:0] pv0, pv1;
        logic signed [31:0] expv;
        logic [15:0] av, bv;
        int dig[8];
        int bc, dc;
        longint sum;
        bit range_ok;
        for (int i = 0; i < 200; i++) begin
            av = 16'($urandom); bv = 16'($urandom);
            if (i % 9 == 0) av = 16'h8000;
            if (i % 11 == 0) bv = 16'h8000;
            expv = $signed(av) * $signed(bv);
            run16(av, bv, 1'b0, pv0, dig, bc, dc);
            run16(av, bv, 1'b1, pv1, dig, bc, dc);
            tests_run++;
            if (pv0 !== expv || pv1 !== expv) begin
                fails++;
                $display("FAIL rand16 a=%h b=%h: mb=%h nr=%h, required %h", av, bv, pv0, pv1, expv);
            end
            sum = 0;
            range_ok = 1'b1;
            for (int k = 7; k >= 0; k--) begin
                sum = sum * 4 + longint'(dig[k]);
                if (k < 7 && (dig[k] < -2 || dig[k] > 1)) range_ok = 1'b0;
            end
            tests_run++;
            if (sum != longint'($signed(av)) || !range_ok || dig[7] < -2 || dig[7] > 2) begin
                fails++;
                $display("FAIL rand16_digits a=%h: digit sum=%0d range_ok=%b, required %0d in range",
                         av, sum, range_ok, $signed(av));
            end
        end
    endtask

    task automatic test_random8();
        logic [7:0] av, bv;
        logic signed [15:0] expv;
        int cyc;
        for (int i = 0; i < 1000; i++) begin
            av = 8'($urandom); bv = 8'($urandom);
            if (i % 7 == 0) av = 8'h80;
            if (i % 13 == 0) bv = 8'h80;
            expv = $signed(av) * $signed(bv);
            @(negedge clk);
            a8 = av; b8 = bv; m8 = 1'($urandom); s8 = 1'b1;
            @(negedge clk);
            s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
            cyc = 1;
            while (!done8 && cyc < 30) begin
                @(negedge clk);
                cyc++;
            end
            tests_run++;
            if (p8 !== expv || cyc != 5) begin
                fails++;
                $display("FAIL rand8 a=%h b=%h: p=%h latency=%0d, required %h and 5", av, bv, p8, cyc, expv);
            end
        end
    endtask

    task automatic test_random32();
        logic [31:0] av, bv;
        logic signed [63:0] expv;
        int cyc;
        for (int i = 0; i < 500; i++) begin
            av = $urandom; bv = $urandom;
            if (i % 7 == 0) av = 32'h80000000;
            if (i % 13 == 0) bv = 32'h80000000;
            expv = $signed(av) * $signed(bv);
            @(negedge clk);
            a32 = av; b32 = bv; m32 = 1'($urandom); s32 = 1'b1;
            @(negedge clk);
            s32 = 1'b0; a32 = $urandom; b32 = $urandom;
            cyc = 1;
            while (!done32 && cyc < 60) begin
                @(negedge clk);
                cyc++;
            end
            tests_run++;
            if (p32 !== expv || cyc != 17) begin
                fails++;
                $display("FAIL rand32 a=%h b=%h: p=%h latency=%0d, required %h and 17", av, bv, p32, cyc, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_digits();
        test_back_to_back();
        test_start_in_run();
        test_async_reset();
        test_random16();
        test_random8();
        test_random32();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
